// File: rtl/hazard_ctl.sv
// hazard_ctl: decode-stage RAW hazard detector and issue controller feeding ID/EX.
// Tracks in-flight writers for EX/MEM/WB, stalls decode on hazards, injects bubbles,
// and sequences the HALT drain.
// Ports:
//   clk, rst            clock, asynchronous active-high reset
//   id_*                decode-stage instruction fields
//   ex_flush            taken branch/jump in EX; the decode instruction is wrong-path
//   stall_fetch         hold PC and IF/ID
//   issue / bubble      decode instruction enters ID/EX, or ID/EX latches a NOP
//   halted, drain_busy  HALT sequencing status
//   stall_cycles        saturating count of hazard-stall cycles
module hazard_ctl #(
    parameter int unsigned FORWARDING = 1,
    parameter int unsigned WB_BYPASS  = 1,
    parameter int unsigned CNT_W      = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             id_valid,
    input  logic [2:0]       id_rX,
    input  logic             id_rX_used,
    input  logic [2:0]       id_rY,
    input  logic             id_rY_used,
    input  logic [2:0]       id_rO,
    input  logic             id_writes,
    input  logic             id_is_load,
    input  logic             id_halt,
    input  logic             ex_flush,
    output logic             stall_fetch,
    output logic             issue,
    output logic             bubble,
    output logic             halted,
    output logic             drain_busy,
    output logic [CNT_W-1:0] stall_cycles
);

    typedef struct packed {
        logic       valid;
        logic       writes;
        logic [2:0] rd;
        logic       is_load;
    } sb_entry_t;

    typedef enum logic [1:0] {
        RUN    = 2'd0,
        DRAIN  = 2'd1,
        HALTED = 2'd2
    } state_t;

    state_t    state;
    state_t    state_next;
    sb_entry_t sb_ex;
    sb_entry_t sb_mem;
    sb_entry_t sb_wb;
    sb_entry_t sb_in;
    logic      hazard;

    function automatic logic sb_match(input sb_entry_t s, input logic [2:0] r);
        return s.valid & s.writes & (s.rd == r);
    endfunction

    // With forwarding only a load still in EX cannot supply its result in time.
    function automatic logic src_hazard(input logic used, input logic [2:0] r,
                                        input sb_entry_t ex, input sb_entry_t mem,
                                        input sb_entry_t wb);
        logic h;
        if (FORWARDING != 0) begin
            h = sb_match(ex, r) & ex.is_load;
        end else begin
            h = sb_match(ex, r) | sb_match(mem, r) |
                ((WB_BYPASS == 0) & sb_match(wb, r));
        end
        return used & h;
    endfunction

    // Hazard, issue and next-state decode
    always_comb begin
        hazard      = id_valid & (state == RUN) &
                      (src_hazard(id_rX_used, id_rX, sb_ex, sb_mem, sb_wb) |
                       src_hazard(id_rY_used, id_rY, sb_ex, sb_mem, sb_wb));
        issue       = 1'b0;
        stall_fetch = 1'b1;
        drain_busy  = 1'b0;
        halted      = 1'b0;
        state_next  = state;
        case (state)
            RUN: begin
                issue       = id_valid & ~hazard & ~ex_flush;
                stall_fetch = hazard & ~ex_flush;
                if (issue & id_halt) state_next = DRAIN;
            end
            DRAIN: begin
                drain_busy = 1'b1;
                // Nothing issues while draining, so with EX and MEM empty the
                // whole scoreboard is empty after this edge.
                if (~sb_ex.valid & ~sb_mem.valid) state_next = HALTED;
            end
            HALTED: begin
                halted = 1'b1;
            end
            default: begin
                state_next = RUN;
            end
        endcase
    end

    assign bubble = ~issue;

    // Entry pushed into EX: the issued instruction or an all-zero bubble
    always_comb begin
        sb_in = '0;
        if (issue) begin
            sb_in.valid   = 1'b1;
            sb_in.writes  = id_writes;
            sb_in.rd      = id_rO;
            sb_in.is_load = id_is_load;
        end
    end

    // Scoreboard shift, FSM state and saturating stall counter
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state        <= RUN;
            sb_ex        <= '0;
            sb_mem       <= '0;
            sb_wb        <= '0;
            stall_cycles <= '0;
        end else begin
            state  <= state_next;
            sb_wb  <= sb_mem;
            sb_mem <= sb_ex;
            sb_ex  <= sb_in;
            if (hazard & ~ex_flush & ~(&stall_cycles)) begin
                stall_cycles <= stall_cycles + CNT_W'(1);
            end
        end
    end

endmodule

// File: tb/tb_hazard_ctl.sv
// Bench for hazard_ctl: four configurations share one stimulus stream.
//   k0: FORWARDING=1                 k1: FORWARDING=0, WB_BYPASS=1
//   k2: FORWARDING=0, WB_BYPASS=0    k3: as k1 with a 3-bit counter
module tb_hazard_ctl;

    localparam int NDUT = 4;

    logic       clk = 1'b0;
    logic       rst;
    logic       id_valid;
    logic [2:0] id_rx;
    logic       id_rx_used;
    logic [2:0] id_ry;
    logic       id_ry_used;
    logic [2:0] id_ro;
    logic       id_writes;
    logic       id_is_load;
    logic       id_halt;
    logic       ex_flush;

    logic        issue_o [NDUT];
    logic        stall_o [NDUT];
    logic        bubble_o[NDUT];
    logic        halted_o[NDUT];
    logic        drain_o [NDUT];
    logic [15:0] cnt0, cnt1, cnt2;
    logic [2:0]  cnt3;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    hazard_ctl #(.FORWARDING(1), .WB_BYPASS(1), .CNT_W(16)) u_f (
        .clk(clk), .rst(rst), .id_valid(id_valid), .id_rX(id_rx), .id_rX_used(id_rx_used),
        .id_rY(id_ry), .id_rY_used(id_ry_used), .id_rO(id_ro), .id_writes(id_writes),
        .id_is_load(id_is_load), .id_halt(id_halt), .ex_flush(ex_flush),
        .stall_fetch(stall_o[0]), .issue(issue_o[0]), .bubble(bubble_o[0]),
        .halted(halted_o[0]), .drain_busy(drain_o[0]), .stall_cycles(cnt0));

    hazard_ctl #(.FORWARDING(0), .WB_BYPASS(1), .CNT_W(16)) u_n (
        .clk(clk), .rst(rst), .id_valid(id_valid), .id_rX(id_rx), .id_rX_used(id_rx_used),
        .id_rY(id_ry), .id_rY_used(id_ry_used), .id_rO(id_ro), .id_writes(id_writes),
        .id_is_load(id_is_load), .id_halt(id_halt), .ex_flush(ex_flush),
        .stall_fetch(stall_o[1]), .issue(issue_o[1]), .bubble(bubble_o[1]),
        .halted(halted_o[1]), .drain_busy(drain_o[1]), .stall_cycles(cnt1));

    hazard_ctl #(.FORWARDING(0), .WB_BYPASS(0), .CNT_W(16)) u_nw (
        .clk(clk), .rst(rst), .id_valid(id_valid), .id_rX(id_rx), .id_rX_used(id_rx_used),
        .id_rY(id_ry), .id_rY_used(id_ry_used), .id_rO(id_ro), .id_writes(id_writes),
        .id_is_load(id_is_load), .id_halt(id_halt), .ex_flush(ex_flush),
        .stall_fetch(stall_o[2]), .issue(issue_o[2]), .bubble(bubble_o[2]),
        .halted(halted_o[2]), .drain_busy(drain_o[2]), .stall_cycles(cnt2));

    hazard_ctl #(.FORWARDING(0), .WB_BYPASS(1), .CNT_W(3)) u_sat (
        .clk(clk), .rst(rst), .id_valid(id_valid), .id_rX(id_rx), .id_rX_used(id_rx_used),
        .id_rY(id_ry), .id_rY_used(id_ry_used), .id_rO(id_ro), .id_writes(id_writes),
        .id_is_load(id_is_load), .id_halt(id_halt), .ex_flush(ex_flush),
        .stall_fetch(stall_o[3]), .issue(issue_o[3]), .bubble(bubble_o[3]),
        .halted(halted_o[3]), .drain_busy(drain_o[3]), .stall_cycles(cnt3));

    // ---------------- reference model ----------------
    // hist[k][a] = instruction issued a+1 cycles ago (bubble when nothing issued).
    // age[k]     = cycles since HALT issued (0 = no HALT yet).
    typedef struct {
        bit       v;
        bit       w;
        bit [2:0] rd;
        bit       ld;
    } ent_t;

    ent_t hist[NDUT][3];
    int   age [NDUT];
    int   cnt [NDUT];

    function automatic bit cfg_fwd(input int k);
        return k == 0;
    endfunction

    function automatic bit cfg_byp(input int k);
        return k != 2;
    endfunction

    function automatic int cfg_max(input int k);
        return (k == 3) ? 7 : 65535;
    endfunction

    function automatic int get_cnt(input int k);
        case (k)
            0: return int'(cnt0);
            1: return int'(cnt1);
            2: return int'(cnt2);
            default: return int'(cnt3);
        endcase
    endfunction

    // A source is blocked if a writer of it is too young to supply its value.
    function automatic bit m_hz(input int k, input bit used, input bit [2:0] r);
        bit   h;
        ent_t e;
        h = 1'b0;
        if (!used) return 1'b0;
        for (int a = 0; a < 3; a++) begin
            e = hist[k][a];
            if (e.v && e.w && e.rd == r) begin
                if (cfg_fwd(k)) begin
                    if (a == 0 && e.ld) h = 1'b1;
                end else if (a < 2 || !cfg_byp(k)) begin
                    h = 1'b1;
                end
            end
        end
        return h;
    endfunction

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        for (int k = 0; k < NDUT; k++) begin
            for (int a = 0; a < 3; a++) hist[k][a] = '{1'b0, 1'b0, 3'd0, 1'b0};
            age[k] = 0;
            cnt[k] = 0;
        end
    endtask

    // Compare all DUTs against the model for the current inputs; optionally advance.
    task automatic model_step(input bit commit);
        bit run, hz, e_iss, e_stl;
        for (int k = 0; k < NDUT; k++) begin
            run   = (age[k] == 0);
            hz    = run && id_valid && (m_hz(k, id_rx_used, id_rx) || m_hz(k, id_ry_used, id_ry));
            e_iss = run && id_valid && !hz && !ex_flush;
            e_stl = run ? (hz && !ex_flush) : 1'b1;
            chk($sformatf("issue[%0d]", k), int'(issue_o[k]), int'(e_iss));
            chk($sformatf("bubble[%0d]", k), int'(bubble_o[k]), int'(!e_iss));
            chk($sformatf("stall_fetch[%0d]", k), int'(stall_o[k]), int'(e_stl));
            chk($sformatf("drain_busy[%0d]", k), int'(drain_o[k]), int'(age[k] >= 1 && age[k] <= 3));
            chk($sformatf("halted[%0d]", k), int'(halted_o[k]), int'(age[k] >= 4));
            chk($sformatf("stall_cycles[%0d]", k), get_cnt(k), cnt[k]);
            if (commit) begin
                if (hz && !ex_flush && cnt[k] < cfg_max(k)) cnt[k]++;
                hist[k][2] = hist[k][1];
                hist[k][1] = hist[k][0];
                if (e_iss) hist[k][0] = '{1'b1, id_writes, id_ro, id_is_load};
                else       hist[k][0] = '{1'b0, 1'b0, 3'd0, 1'b0};
                if (e_iss && id_halt) age[k] = 1;
                else if (age[k] > 0 && age[k] < 4) age[k]++;
            end
        end
    endtask

    task automatic drive(input bit v, input bit [2:0] rx, input bit rxu, input bit [2:0] ry,
                         input bit ryu, input bit [2:0] ro, input bit w, input bit ld,
                         input bit hlt, input bit fl);
        id_valid = v; id_rx = rx; id_rx_used = rxu; id_ry = ry; id_ry_used = ryu;
        id_ro = ro; id_writes = w; id_is_load = ld; id_halt = hlt; ex_flush = fl;
    endtask

    // Called at a negedge with inputs set; reset spans one posedge.
    task automatic apply_reset();
        ex_flush = 1'b0;
        rst = 1'b1;
        #1;
        model_reset();
        for (int k = 0; k < NDUT; k++) begin
            chk($sformatf("rst_issue[%0d]", k), int'(issue_o[k]), int'(id_valid));
            chk($sformatf("rst_stall[%0d]", k), int'(stall_o[k]), 0);
        end
        model_step(1'b0);
        @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic cyc();
        #1;
        model_step(1'b1);
        @(negedge clk);
    endtask

    // ---------------- directed table ----------------
    typedef struct {
        bit       v;
        bit [2:0] rx;
        bit       rxu;
        bit [2:0] ry;
        bit       ryu;
        bit [2:0] ro;
        bit       w;
        bit       ld;
        bit       fl;
        bit       iss_f;
        bit       stl_f;
        bit       iss_n;
        bit       stl_n;
    } vec_t;

    vec_t tbl[$];

    task automatic add_idle3();
        for (int i = 0; i < 3; i++)
            tbl.push_back('{1'b0, 3'd0, 1'b0, 3'd0, 1'b0, 3'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0});
    endtask

    initial begin
        // load r3 then read r3: fwd stalls 1, no-fwd stalls 2
        tbl.push_back('{1'b1, 3'd0, 1'b0, 3'd0, 1'b0, 3'd3, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0});
        tbl.push_back('{1'b1, 3'd3, 1'b1, 3'd0, 1'b0, 3'd4, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1});
        tbl.push_back('{1'b1, 3'd3, 1'b1, 3'd0, 1'b0, 3'd4, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1});
        tbl.push_back('{1'b1, 3'd3, 1'b1, 3'd0, 1'b0, 3'd4, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0});
        add_idle3();
        // ALU write r3 then read r3: no stall with forwarding
        tbl.push_back('{1'b1, 3'd0, 1'b0, 3'd0, 1'b0, 3'd3, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0});
        tbl.push_back('{1'b1, 3'd3, 1'b1, 3'd0, 1'b0, 3'd0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1});
        tbl.push_back('{1'b1, 3'd3, 1'b1, 3'd0, 1'b0, 3'd0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1});
        tbl.push_back('{1'b1, 3'd3, 1'b1, 3'd0, 1'b0, 3'd0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0});
        add_idle3();
        // write r5 then read rY=r5
        tbl.push_back('{1'b1, 3'd0, 1'b0, 3'd0, 1'b0, 3'd5, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0});
        tbl.push_back('{1'b1, 3'd0, 1'b0, 3'd5, 1'b1, 3'd0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1});
        tbl.push_back('{1'b1, 3'd0, 1'b0, 3'd5, 1'b1, 3'd0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1});
        tbl.push_back('{1'b1, 3'd0, 1'b0, 3'd5, 1'b1, 3'd0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0});
        add_idle3();
        // write r5 then rY=r5 with rY_used=0: no stall
        tbl.push_back('{1'b1, 3'd0, 1'b0, 3'd0, 1'b0, 3'd5, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0});
        tbl.push_back('{1'b1, 3'd1, 1'b1, 3'd5, 1'b0, 3'd0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0});
        add_idle3();
        // hazard with ex_flush, then a fresh instruction
        tbl.push_back('{1'b1, 3'd0, 1'b0, 3'd0, 1'b0, 3'd3, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0});
        tbl.push_back('{1'b1, 3'd3, 1'b1, 3'd0, 1'b0, 3'd0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0});
        tbl.push_back('{1'b1, 3'd6, 1'b1, 3'd0, 1'b0, 3'd0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0});
        add_idle3();
    end

    // ---------------- main sequence ----------------
    initial begin
        rst = 1'b1;
        drive(1'b1, 3'd3, 1'b1, 3'd0, 1'b0, 3'd0, 1'b0, 1'b0, 1'b0, 1'b0);
        @(negedge clk);
        apply_reset();

        // Table vectors
        for (int i = 0; i < tbl.size(); i++) begin
            drive(tbl[i].v, tbl[i].rx, tbl[i].rxu, tbl[i].ry, tbl[i].ryu, tbl[i].ro,
                  tbl[i].w, tbl[i].ld, 1'b0, tbl[i].fl);
            #1;
            chk($sformatf("tbl%0d_issue_f", i), int'(issue_o[0]), int'(tbl[i].iss_f));
            chk($sformatf("tbl%0d_stall_f", i), int'(stall_o[0]), int'(tbl[i].stl_f));
            chk($sformatf("tbl%0d_issue_n", i), int'(issue_o[1]), int'(tbl[i].iss_n));
            chk($sformatf("tbl%0d_stall_n", i), int'(stall_o[1]), int'(tbl[i].stl_n));
            model_step(1'b1);
            @(negedge clk);
        end
        #1;
        chk("tbl_cnt_f", int'(cnt0), 1);
        chk("tbl_cnt_n", int'(cnt1), 6);
        @(negedge clk);

        // HALT from an empty pipeline; later id_valid and ex_flush ignored
        drive(1'b1, 3'd0, 1'b0, 3'd0, 1'b0, 3'd0, 1'b0, 1'b0, 1'b1, 1'b0);
        #1;
        for (int k = 0; k < NDUT; k++) chk($sformatf("halt_issue[%0d]", k), int'(issue_o[k]), 1);
        model_step(1'b1);
        @(negedge clk);
        for (int j = 1; j <= 6; j++) begin
            drive(1'b1, 3'd2, 1'b1, 3'd1, 1'b1, 3'd4, 1'b1, 1'b0, 1'b0, bit'(j % 2));
            #1;
            for (int k = 0; k < NDUT; k++) begin
                chk($sformatf("hd%0d_drain[%0d]", j, k), int'(drain_o[k]), int'(j <= 3));
                chk($sformatf("hd%0d_halted[%0d]", j, k), int'(halted_o[k]), int'(j >= 4));
                chk($sformatf("hd%0d_stall[%0d]", j, k), int'(stall_o[k]), 1);
                chk($sformatf("hd%0d_issue[%0d]", j, k), int'(issue_o[k]), 0);
            end
            model_step(1'b1);
            @(negedge clk);
        end
        apply_reset();

        // HALT behind a load-use hazard waits, then issues and drains
        drive(1'b1, 3'd0, 1'b0, 3'd0, 1'b0, 3'd2, 1'b1, 1'b1, 1'b0, 1'b0);
        cyc();
        for (int j = 1; j <= 8; j++) begin
            drive(1'b1, 3'd2, 1'b1, 3'd0, 1'b0, 3'd0, 1'b0, 1'b0, 1'b1, 1'b0);
            #1;
            if (j == 1) chk("hh_stall_f", int'(stall_o[0]), 1);
            if (j == 2) chk("hh_issue_f", int'(issue_o[0]), 1);
            if (j == 3) chk("hh_issue_n", int'(issue_o[1]), 1);
            if (j == 5) chk("hh_drain_f", int'(drain_o[0]), 1);
            if (j == 6) chk("hh_halted_f", int'(halted_o[0]), 1);
            if (j == 7) chk("hh_halted_n", int'(halted_o[1]), 1);
            model_step(1'b1);
            @(negedge clk);
        end
        apply_reset();

        // Reset in the middle of a drain
        drive(1'b1, 3'd0, 1'b0, 3'd0, 1'b0, 3'd0, 1'b0, 1'b0, 1'b1, 1'b0);
        cyc();
        drive(1'b1, 3'd3, 1'b1, 3'd0, 1'b0, 3'd3, 1'b1, 1'b0, 1'b0, 1'b0);
        cyc();
        drive(1'b1, 3'd3, 1'b1, 3'd0, 1'b0, 3'd3, 1'b1, 1'b0, 1'b0, 1'b0);
        rst = 1'b1;
        #1;
        for (int k = 0; k < NDUT; k++) begin
            chk($sformatf("mdr_drain[%0d]", k), int'(drain_o[k]), 0);
            chk($sformatf("mdr_halted[%0d]", k), int'(halted_o[k]), 0);
        end
        rst = 1'b0;
        @(negedge clk);
        apply_reset();
        #1;
        for (int k = 0; k < NDUT; k++) begin
            chk($sformatf("post_rst_issue[%0d]", k), int'(issue_o[k]), 1);
            chk($sformatf("post_rst_stall[%0d]", k), int'(stall_o[k]), 0);
        end
        model_step(1'b1);
        @(negedge clk);

        // Randomized traffic against the model
        for (int n = 0; n < 3000; n++) begin
            if ((age[0] >= 4 && age[1] >= 4 && age[2] >= 4 && age[3] >= 4) ||
                $urandom_range(0, 199) == 0) begin
                drive(bit'($urandom_range(0, 1)), 3'($urandom_range(0, 3)), 1'b1, 3'd0, 1'b0,
                      3'd0, 1'b0, 1'b0, 1'b0, 1'b0);
                apply_reset();
            end
            drive($urandom_range(0, 9) < 8,
                  3'($urandom_range(0, 3)), $urandom_range(0, 9) < 7,
                  3'($urandom_range(0, 3)), $urandom_range(0, 9) < 7,
                  3'($urandom_range(0, 3)), $urandom_range(0, 9) < 6,
                  $urandom_range(0, 9) < 3, $urandom_range(0, 49) == 0,
                  $urandom_range(0, 9) == 0);
            cyc();
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
